// File: rtl/cardinal_vc_router_pkg.sv
// -----------------------------------------------------------------------------
// cardinal_pkg
// Shared definitions for the cardinal_vc_router mesh node:
//   - port index constants (NIC, UP, DOWN, LEFT, RIGHT) and NUM_PORTS
//   - coordinate width helper and header field offset helpers
//   - route_t: result of XY routing for one flit
// -----------------------------------------------------------------------------
package cardinal_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PORT_W    = 3;

    // Port order doubles as round-robin priority order.
    localparam int NIC   = 0;
    localparam int UP    = 1;
    localparam int DOWN  = 2;
    localparam int LEFT  = 3;
    localparam int RIGHT = 4;

    typedef struct packed {
        logic              valid;  // destination lies inside the mesh
        logic [PORT_W-1:0] port;   // output port chosen by XY routing
    } route_t;

    // Coordinate field width: wide enough for either mesh dimension, never 0.
    function automatic int cw_of(input int mesh_x, input int mesh_y);
        int w;
        w = ($clog2(mesh_x) > $clog2(mesh_y)) ? $clog2(mesh_x) : $clog2(mesh_y);
        return (w < 1) ? 1 : w;
    endfunction

    // dst_x sits directly below the VC bit, dst_y directly below dst_x.
    function automatic int dst_x_lsb(input int data_w, input int cw);
        return data_w - 1 - cw;
    endfunction

    function automatic int dst_y_lsb(input int data_w, input int cw);
        return data_w - 1 - 2 * cw;
    endfunction

endpackage

// File: rtl/cardinal_vc_router_if.sv
// -----------------------------------------------------------------------------
// cardinal_vc_router_if
// Bundles the five router links (NIC, up, down, left, right) plus the global
// polarity indication. Per port P:
//   P_si/P_di : flit valid/data into the router
//   P_ri      : router input buffer ready
//   P_so/P_do : flit valid/data out of the router
//   P_ro      : downstream ready
// Modports: master = node/link side driving flits in, slave = router.
// -----------------------------------------------------------------------------
interface cardinal_vc_router_if #(
    parameter int DATA_W = 64
);
    logic              NIC_si,   up_si,   down_si,   left_si,   right_si;
    logic [DATA_W-1:0] NIC_di,   up_di,   down_di,   left_di,   right_di;
    logic              NIC_ri,   up_ri,   down_ri,   left_ri,   right_ri;
    logic              NIC_so,   up_so,   down_so,   left_so,   right_so;
    logic [DATA_W-1:0] NIC_do,   up_do,   down_do,   left_do,   right_do;
    logic              NIC_ro,   up_ro,   down_ro,   left_ro,   right_ro;
    logic              polarity_to_NIC;

    modport master (
        output NIC_si, up_si, down_si, left_si, right_si,
        output NIC_di, up_di, down_di, left_di, right_di,
        output NIC_ro, up_ro, down_ro, left_ro, right_ro,
        input  NIC_ri, up_ri, down_ri, left_ri, right_ri,
        input  NIC_so, up_so, down_so, left_so, right_so,
        input  NIC_do, up_do, down_do, left_do, right_do,
        input  polarity_to_NIC
    );

    modport slave (
        input  NIC_si, up_si, down_si, left_si, right_si,
        input  NIC_di, up_di, down_di, left_di, right_di,
        input  NIC_ro, up_ro, down_ro, left_ro, right_ro,
        output NIC_ri, up_ri, down_ri, left_ri, right_ri,
        output NIC_so, up_so, down_so, left_so, right_so,
        output NIC_do, up_do, down_do, left_do, right_do,
        output polarity_to_NIC
    );
endinterface

// File: rtl/cardinal_rr_arb.sv
// -----------------------------------------------------------------------------
// cardinal_rr_arb
// Five-request round-robin arbiter with one-hot grant.
//   clk, reset : clock, asynchronous active-low reset
//   en         : arbitration allowed this cycle (right VC phase, output free)
//   req[4:0]   : requests indexed by input port (NIC=0 ... right=4)
//   gnt[4:0]   : one-hot grant, zero when en is low or nothing requests
// The pointer marks the highest-priority requester; after a grant it moves to
// grantee+1 (mod 5), and it holds while nothing is granted.
// -----------------------------------------------------------------------------
module cardinal_rr_arb
    import cardinal_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt
);
    logic [PORT_W-1:0] ptr, ptr_next;

    always_comb begin
        int   idx;
        logic found;
        // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
        idx      = 0;
        found    = 1'b0;
        gnt      = '0;
        ptr_next = ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_next = (idx == NUM_PORTS - 1) ? '0 : PORT_W'(idx + 1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr <= '0;
        else        ptr <= ptr_next;
    end
endmodule

// File: rtl/cardinal_vc_router.sv
// -----------------------------------------------------------------------------
// cardinal_vc_router
// Five-port mesh router node with even/odd virtual channels, XY routing and
// per-output round-robin arbitration. Single-flit packets.
//   clk, reset : clock, asynchronous active-low reset
//   link       : cardinal_vc_router_if.slave (all five links + polarity_to_NIC)
//   flit_cnt   : only with CARDINAL_ROUTER_STATS_EN defined; entries 0..4 count
//                flits forwarded per output port, entry 5 counts dropped flits.
// A global polarity bit p toggles every cycle. Ingress and egress serve VC p;
// the switch moves VC !p from input buffers to output registers, so each
// buffer fills in one phase and drains in the other.
// -----------------------------------------------------------------------------
module cardinal_vc_router
    import cardinal_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int MESH_X = 4,
    parameter int MESH_Y = 4,
    parameter int X_POS  = 0,
    parameter int Y_POS  = 0
) (
    input logic                 clk,
    input logic                 reset,
    cardinal_vc_router_if.slave link
`ifdef CARDINAL_ROUTER_STATS_EN
    ,
    output logic [5:0][31:0]    flit_cnt
`endif
);
    localparam int CW    = cw_of(MESH_X, MESH_Y);
    localparam int X_LSB = dst_x_lsb(DATA_W, CW);
    localparam int Y_LSB = dst_y_lsb(DATA_W, CW);

    // Port-indexed views of the link bundle.
    logic [NUM_PORTS-1:0] si, ri, so, ro;
    logic [DATA_W-1:0]    di   [NUM_PORTS];
    logic [DATA_W-1:0]    dout [NUM_PORTS];

    assign si = {link.right_si, link.left_si, link.down_si, link.up_si, link.NIC_si};
    assign ro = {link.right_ro, link.left_ro, link.down_ro, link.up_ro, link.NIC_ro};
    assign di[NIC]   = link.NIC_di;
    assign di[UP]    = link.up_di;
    assign di[DOWN]  = link.down_di;
    assign di[LEFT]  = link.left_di;
    assign di[RIGHT] = link.right_di;

    assign {link.right_ri, link.left_ri, link.down_ri, link.up_ri, link.NIC_ri} = ri;
    assign {link.right_so, link.left_so, link.down_so, link.up_so, link.NIC_so} = so;
    assign link.NIC_do   = dout[NIC];
    assign link.up_do    = dout[UP];
    assign link.down_do  = dout[DOWN];
    assign link.left_do  = dout[LEFT];
    assign link.right_do = dout[RIGHT];

    // State: one single-entry buffer per input per VC, one register per output per VC.
    logic              polarity;
    logic              in_full  [NUM_PORTS][2];
    logic [DATA_W-1:0] in_data  [NUM_PORTS][2];
    logic              out_full [NUM_PORTS][2];
    logic [DATA_W-1:0] out_data [NUM_PORTS][2];

    logic sw_vc;  // VC being switched this cycle
    assign sw_vc = ~polarity;
    assign link.polarity_to_NIC = polarity;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            ri[p]   = ~in_full[p][polarity];
            so[p]   = out_full[p][polarity];
            dout[p] = out_data[p][polarity];
        end
    end

    // XY dimension-ordered routing; out-of-mesh destinations are flagged invalid.
    function automatic route_t route(input logic [CW-1:0] dx, input logic [CW-1:0] dy);
        route_t r;
        r.valid = 1'b1;
        r.port  = PORT_W'(NIC);
        if (int'(dx) >= MESH_X || int'(dy) >= MESH_Y) r.valid = 1'b0;
        else if (int'(dx) > X_POS)                    r.port  = PORT_W'(RIGHT);
        else if (int'(dx) < X_POS)                    r.port  = PORT_W'(LEFT);
        else if (int'(dy) > Y_POS)                    r.port  = PORT_W'(UP);
        else if (int'(dy) < Y_POS)                    r.port  = PORT_W'(DOWN);
        return r;
    endfunction

    logic [NUM_PORTS-1:0] req     [NUM_PORTS];  // req[out][in]
    logic [NUM_PORTS-1:0] gnt     [NUM_PORTS];  // gnt[out][in], active VC only
    logic [NUM_PORTS-1:0] gnt_vc  [NUM_PORTS][2];
    logic [NUM_PORTS-1:0] drop_in;
    logic [NUM_PORTS-1:0] taken;
    logic [DATA_W-1:0]    xbar    [NUM_PORTS];

    always_comb begin
        route_t r;
        for (int o = 0; o < NUM_PORTS; o++) req[o] = '0;
        drop_in = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            r = route(in_data[i][sw_vc][X_LSB +: CW], in_data[i][sw_vc][Y_LSB +: CW]);
            if (in_full[i][sw_vc]) begin
                if (r.valid) req[r.port][i] = 1'b1;
                else         drop_in[i]     = 1'b1;
            end
        end
    end

    // One arbiter per output per VC; only the VC being switched may grant, and
    // only into an empty output register.
    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        for (genvar v = 0; v < 2; v++) begin : g_vc
            cardinal_rr_arb u_arb (
                .clk   (clk),
                .reset (reset),
                .en    ((sw_vc == 1'(v)) && !out_full[o][v]),
                .req   (req[o]),
                .gnt   (gnt_vc[o][v])
            );
        end
        assign gnt[o] = gnt_vc[o][sw_vc];
    end

    // Crossbar: one-hot grant selects the winning input buffer.
    always_comb begin
        taken = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            xbar[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (gnt[o][i]) begin
                    xbar[o]  = xbar[o] | in_data[i][sw_vc];
                    taken[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity <= 1'b0;
            // NOTE: data storage is reset too, because the outputs must read 0 straight out of reset.
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int v = 0; v < 2; v++) begin
                    in_full[p][v]  <= 1'b0;
                    in_data[p][v]  <= '0;
                    out_full[p][v] <= 1'b0;
                    out_data[p][v] <= '0;
                end
            end
        end else begin
            polarity <= ~polarity;
            for (int p = 0; p < NUM_PORTS; p++) begin
                // Ingress: only flits tagged with the current polarity are taken.
                if (si[p] && ri[p] && (di[p][DATA_W-1] == polarity)) begin
                    in_full[p][polarity] <= 1'b1;
                    in_data[p][polarity] <= di[p];
                end
                if (taken[p] || drop_in[p]) in_full[p][sw_vc] <= 1'b0;
                // Egress handshake on the current VC.
                if (so[p] && ro[p]) out_full[p][polarity] <= 1'b0;
                if (|gnt[p]) begin
                    out_full[p][sw_vc] <= 1'b1;
                    out_data[p][sw_vc] <= xbar[p];
                end
            end
        end
    end

`ifdef CARDINAL_ROUTER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flit_cnt <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (|gnt[o]) flit_cnt[o] <= flit_cnt[o] + 32'd1;
            end
            flit_cnt[5] <= flit_cnt[5] + 32'($countones(drop_in));
        end
    end
`endif

endmodule
